// File: rtl/register_transfer_sequencer.sv
// Register-transfer sequencer: fetches one instruction byte (plus an optional immediate)
// and steps the register file, ALU and output port through MOV, LDI, ALU and OUT.
//
// state  | meaning
// IDLE   | ready for an instruction byte
// DECODE | instruction latched, choose the IMM or EXEC path
// IMM    | waiting for the immediate byte, then write it to dst
// EXEC   | register read: MOV/OUT complete here, ALU latches operands
// WB     | ALU result written back to dst
module register_transfer_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr,
  input  logic       imm_valid,
  output logic       imm_ready,
  input  logic [7:0] imm_data,
  output logic [7:0] imm_bus,
  output logic       imm_enable,
  output logic [1:0] in_regselect,
  output logic [1:0] out_regselect,
  output logic [1:0] alu_regselect,
  output logic       load,
  output logic       enable,
  output logic       alu_latch,
  output logic       alu_enable,
  output logic       port_strobe,
  output logic       busy,
  output logic [7:0] retired_count
);

  typedef enum logic [2:0] {IDLE, DECODE, IMM, EXEC, WB} state_t;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  state_t     state, state_next;
  logic [5:0] instr_q;
  logic       retire;
  logic [1:0] op, dst, src;
  logic       unused_instr_bits;

  // The low two instruction bits carry no meaning and are not stored.
  assign unused_instr_bits = ^instr[1:0];

  assign op  = instr_q[5:4];
  assign dst = instr_q[3:2];
  assign src = instr_q[1:0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      instr_q       <= '0;
      retired_count <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && instr_valid) instr_q <= instr[7:2];
      if (retire) retired_count <= retired_count + 8'd1;
    end
  end

  always_comb begin
    state_next    = state;
    retire        = 1'b0;
    instr_ready   = 1'b0;
    imm_ready     = 1'b0;
    imm_bus       = 8'h00;
    imm_enable    = 1'b0;
    in_regselect  = 2'd0;
    out_regselect = 2'd0;
    alu_regselect = 2'd0;
    load          = 1'b0;
    enable        = 1'b0;
    alu_latch     = 1'b0;
    alu_enable    = 1'b0;
    port_strobe   = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = DECODE;
      end
      DECODE: state_next = (op == OP_LDI) ? IMM : EXEC;
      IMM: begin
        imm_ready = 1'b1;
        if (imm_valid) begin
          imm_enable   = 1'b1;
          imm_bus      = imm_data;
          load         = 1'b1;
          in_regselect = dst;
          retire       = 1'b1;
          state_next   = IDLE;
        end
      end
      EXEC: begin
        case (op)
          OP_MOV: begin
            enable        = 1'b1;
            out_regselect = src;
            load          = 1'b1;
            in_regselect  = dst;
            retire        = 1'b1;
            state_next    = IDLE;
          end
          OP_ALU: begin
            // dst is read onto the databus while src feeds the ALU's second port.
            alu_regselect = src;
            out_regselect = dst;
            enable        = 1'b1;
            alu_latch     = 1'b1;
            state_next    = WB;
          end
          OP_OUT: begin
            enable        = 1'b1;
            out_regselect = src;
            port_strobe   = 1'b1;
            retire        = 1'b1;
            state_next    = IDLE;
          end
          default: state_next = IDLE;
        endcase
      end
      WB: begin
        alu_enable   = 1'b1;
        load         = 1'b1;
        in_regselect = dst;
        retire       = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_register_transfer_sequencer.sv
// Bench for register_transfer_sequencer: directed and randomized instruction streams
// compared cycle by cycle against per-opcode expected output sequences.
module tb_register_transfer_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic       imm_valid;
  logic       imm_ready;
  logic [7:0] imm_data;
  logic [7:0] imm_bus;
  logic       imm_enable;
  logic [1:0] in_regselect;
  logic [1:0] out_regselect;
  logic [1:0] alu_regselect;
  logic       load;
  logic       enable;
  logic       alu_latch;
  logic       alu_enable;
  logic       port_strobe;
  logic       busy;
  logic [7:0] retired_count;

  int checks = 0;
  int errors = 0;
  int model_count = 0;

  always #5 clock = ~clock;

  register_transfer_sequencer dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .imm_valid(imm_valid), .imm_ready(imm_ready), .imm_data(imm_data),
    .imm_bus(imm_bus), .imm_enable(imm_enable),
    .in_regselect(in_regselect), .out_regselect(out_regselect), .alu_regselect(alu_regselect),
    .load(load), .enable(enable), .alu_latch(alu_latch), .alu_enable(alu_enable),
    .port_strobe(port_strobe), .busy(busy), .retired_count(retired_count)
  );

  logic [22:0] obs;
  assign obs = {instr_ready, imm_ready, imm_enable, imm_bus, in_regselect, out_regselect,
                alu_regselect, load, enable, alu_latch, alu_enable, port_strobe, busy};

  localparam logic [22:0] IDLE_VEC = 23'h400000;

  function automatic logic [22:0] mk(input int ir, input int mr, input int ie, input int bus,
                                     input int isel, input int osel, input int asel,
                                     input int ld, input int en, input int al, input int ae,
                                     input int ps, input int bz);
    return {1'(ir), 1'(mr), 1'(ie), 8'(bus), 2'(isel), 2'(osel), 2'(asel),
            1'(ld), 1'(en), 1'(al), 1'(ae), 1'(ps), 1'(bz)};
  endfunction

  // Runs one instruction from its accept cycle; expected outputs per cycle come from the opcode rules.
  task automatic run_instr(input logic [7:0] ins, input int nwait, input logic [7:0] imm);
    logic [22:0] expq[$];
    bit          ivq[$];
    int          op, dst, src, n;
    op  = int'(ins[7:6]);
    dst = int'(ins[5:4]);
    src = int'(ins[3:2]);
    expq.push_back(IDLE_VEC);                             ivq.push_back(1'($urandom_range(0, 1)));
    expq.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,1));        ivq.push_back(1'($urandom_range(0, 1)));
    case (op)
      0: begin
        expq.push_back(mk(0,0,0,0,dst,src,0,1,1,0,0,0,1)); ivq.push_back(1'($urandom_range(0, 1)));
      end
      1: begin
        for (int k = 0; k < nwait; k++) begin
          expq.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,0,1));  ivq.push_back(1'b0);
        end
        expq.push_back(mk(0,1,1,int'(imm),dst,0,0,1,0,0,0,0,1)); ivq.push_back(1'b1);
      end
      2: begin
        expq.push_back(mk(0,0,0,0,0,dst,src,0,1,1,0,0,1)); ivq.push_back(1'($urandom_range(0, 1)));
        expq.push_back(mk(0,0,0,0,dst,0,0,1,0,0,1,0,1));   ivq.push_back(1'($urandom_range(0, 1)));
      end
      default: begin
        expq.push_back(mk(0,0,0,0,0,src,0,0,1,0,0,1,1));   ivq.push_back(1'($urandom_range(0, 1)));
      end
    endcase
    n = expq.size();
    for (int i = 0; i < n; i++) begin
      instr_valid = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      instr       = (i == 0) ? ins : 8'($urandom);
      imm_valid   = ivq[i];
      imm_data    = (op == 1 && i == n - 1) ? imm : 8'($urandom);
      @(negedge clock);
      checks++;
      if (obs !== expq[i]) begin
        errors++;
        $display("FAIL seq instr=%h cycle=%0d outputs got %h expected %h", ins, i, obs, expq[i]);
      end
      checks++;
      if (retired_count !== 8'(model_count)) begin
        errors++;
        $display("FAIL seq_count instr=%h cycle=%0d got %0d expected %0d", ins, i, retired_count, model_count);
      end
      checks++;
      if (int'(enable === 1'b1) + int'(imm_enable === 1'b1) + int'(alu_enable === 1'b1) > 1) begin
        errors++;
        $display("FAIL bus_exclusive instr=%h cycle=%0d got en=%b ie=%b ae=%b expected at most one",
                 ins, i, enable, imm_enable, alu_enable);
      end
      @(posedge clock); #1;
    end
    model_count = (model_count + 1) % 256;
    instr_valid = 1'b0;
    imm_valid   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; instr_valid = 1'b0; imm_valid = 1'b0; instr = 8'h00; imm_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      instr_valid = 1'($urandom_range(0, 1)); instr = 8'($urandom);
      imm_valid = 1'($urandom_range(0, 1));   imm_data = 8'($urandom);
      @(negedge clock);
      checks++;
      if ((obs & ~IDLE_VEC) !== 23'h0 || retired_count !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold outputs got %h count %0d expected 0 and 0", obs & ~IDLE_VEC, retired_count);
      end
    end
    instr_valid = 1'b0; imm_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== IDLE_VEC || retired_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_release outputs got %h count %0d expected %h and 0", obs, retired_count, IDLE_VEC);
    end
    @(posedge clock); #1;
    model_count = 0;
  endtask

  task automatic test_mov;
    run_instr(8'h24, 0, 8'h00);
    @(negedge clock);
    checks++;
    if (retired_count !== 8'd1 || obs !== IDLE_VEC) begin
      errors++;
      $display("FAIL mov_retire count got %0d expected 1, outputs got %h expected %h", retired_count, obs, IDLE_VEC);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_ldi;
    run_instr(8'h70, 3, 8'hA5);
    @(negedge clock);
    checks++;
    if (retired_count !== 8'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ldi_retire count got %0d busy %b expected 2 and 0", retired_count, busy);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_alu;
    run_instr(8'h8C, 0, 8'h00);
    @(negedge clock);
    checks++;
    if (retired_count !== 8'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL alu_retire count got %0d busy %b expected 3 and 0", retired_count, busy);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_out;
    run_instr(8'hC8, 0, 8'h00);
    @(negedge clock);
    checks++;
    if (retired_count !== 8'd4 || load !== 1'b0) begin
      errors++;
      $display("FAIL out_retire count got %0d load %b expected 4 and 0", retired_count, load);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_in_wb;
    instr_valid = 1'b1; instr = 8'h8C;
    @(negedge clock);
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL wbrst_accept instr_ready got %b expected 1", instr_ready);
    end
    @(posedge clock); #1;
    instr = 8'h24;
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || instr_ready !== 1'b0) begin
      errors++; $display("FAIL wbrst_decode busy %b ready %b expected 1 and 0", busy, instr_ready);
    end
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (alu_latch !== 1'b1 || alu_regselect !== 2'd3) begin
      errors++; $display("FAIL wbrst_exec alu_latch %b alu_sel %0d expected 1 and 3", alu_latch, alu_regselect);
    end
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (alu_enable !== 1'b1 || load !== 1'b1 || retired_count !== 8'(model_count)) begin
      errors++;
      $display("FAIL wbrst_wb alu_enable %b load %b count %0d expected 1 1 %0d",
               alu_enable, load, retired_count, model_count);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1; instr_valid = 1'b0;
    model_count = 0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || load !== 1'b0 || retired_count !== 8'h00 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wbrst_after busy %b load %b count %0d ready %b expected 0 0 0 1",
               busy, load, retired_count, instr_ready);
    end
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (obs !== IDLE_VEC || retired_count !== 8'h00) begin
      errors++;
      $display("FAIL wbrst_idle outputs got %h count %0d expected %h and 0", obs, retired_count, IDLE_VEC);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_random;
    for (int t = 0; t < 60; t++) begin
      run_instr(8'($urandom), $urandom_range(0, 4), 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        imm_valid = 1'($urandom_range(0, 1));
        @(negedge clock);
        checks++;
        if (obs !== IDLE_VEC || retired_count !== 8'(model_count)) begin
          errors++;
          $display("FAIL random_gap outputs got %h count %0d expected %h and %0d",
                   obs, retired_count, IDLE_VEC, model_count);
        end
        @(posedge clock); #1;
        imm_valid = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    model_count = 0;
    for (int t = 0; t < 256; t++) run_instr({2'b00, 6'($urandom)}, 0, 8'h00);
    @(negedge clock);
    checks++;
    if (retired_count !== 8'h00 || model_count != 0) begin
      errors++;
      $display("FAIL wrap count got %0d expected 0", retired_count);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mov();
    test_ldi();
    test_alu();
    test_out();
    test_reset_in_wb();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
